// File: rtl/rv_pkg.sv
// rv_pkg: register-file geometry and writeback source encoding shared by the
// issue scoreboard, its arbiter and its interface.
package rv_pkg;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    // One-hot mask for a register index; x0 never maps to a bit.
    function automatic logic [NREG-1:0] reg_bit(input logic [REG_AW-1:0] a);
        return (NREG'(1) << a) & ~NREG'(1);
    endfunction
endpackage

// File: rtl/regfile_wb_scoreboard_if.sv
// regfile_wb_scoreboard_if: issue slot, two writeback sources, RegisterFile
// write port and status, seen from the scoreboard (slave) or its driver (master).
interface regfile_wb_scoreboard_if
    import rv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
);
    logic                   iss_valid;
    logic                   iss_ready;
    logic [REG_AW-1:0]      iss_rs1;
    logic                   iss_rs1_en;
    logic [REG_AW-1:0]      iss_rs2;
    logic                   iss_rs2_en;
    logic [REG_AW-1:0]      iss_rd;
    logic                   iss_rd_en;
    logic                   wb0_valid;
    logic                   wb0_ready;
    logic [REG_AW-1:0]      wb0_rd;
    logic [XLEN-1:0]        wb0_data;
    logic                   wb1_valid;
    logic                   wb1_ready;
    logic [REG_AW-1:0]      wb1_rd;
    logic [XLEN-1:0]        wb1_data;
    logic                   rf_we;
    logic [REG_AW-1:0]      rf_wa;
    logic [XLEN-1:0]        rf_wd;
    logic [NREG-1:0]        busy_vec;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport slave (
        input  iss_valid, iss_rs1, iss_rs1_en, iss_rs2, iss_rs2_en, iss_rd, iss_rd_en,
        input  wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
        output iss_ready, wb0_ready, wb1_ready,
        output rf_we, rf_wa, rf_wd, busy_vec, stall_cnt
    );

    modport master (
        output iss_valid, iss_rs1, iss_rs1_en, iss_rs2, iss_rs2_en, iss_rd, iss_rd_en,
        output wb0_valid, wb0_rd, wb0_data, wb1_valid, wb1_rd, wb1_data,
        input  iss_ready, wb0_ready, wb1_ready,
        input  rf_we, rf_wa, rf_wd, busy_vec, stall_cnt
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-way round-robin grant; rr_last names the most recent winner
// and starts at the load unit so the ALU wins the first contention.
module wb_rr_arbiter
    import rv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    wb_src_e rr_last;

    always_comb begin
        grant[0] = req[0] & (!req[1] | rr_last == WB_LSU);
        grant[1] = req[1] & (!req[0] | rr_last == WB_ALU);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_last <= WB_LSU;
        else if (|grant)
            rr_last <= grant[1] ? WB_LSU : WB_ALU;
    end
endmodule

// File: rtl/regfile_wb_scoreboard.sv
// regfile_wb_scoreboard: RAW/WAW issue scoreboard plus the single RegisterFile
// write port shared between the ALU (wb0) and load unit (wb1) writebacks.
module regfile_wb_scoreboard
    import rv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input logic                     clk,
    input logic                     rst,
    regfile_wb_scoreboard_if.slave  bus
);
    logic [NREG-1:0]        busy;
    logic [NREG-1:0]        set_vec;
    logic [NREG-1:0]        clr_vec;
    logic                   hazard;
    logic                   fire;
    logic [1:0]             grant;
    logic [REG_AW-1:0]      win_rd;
    logic [XLEN-1:0]        win_data;
    logic                   we;
    logic [REG_AW-1:0]      wa;
    logic [XLEN-1:0]        wd;
    logic [STALL_CNT_W-1:0] stalls;

    wb_rr_arbiter u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({bus.wb1_valid, bus.wb0_valid}),
        .grant (grant)
    );

    // No bypass: a bit clearing this cycle still blocks, since busy is the register.
    always_comb begin
        hazard   = (bus.iss_rs1_en & busy[bus.iss_rs1])
                 | (bus.iss_rs2_en & busy[bus.iss_rs2])
                 | (bus.iss_rd_en  & busy[bus.iss_rd]);
        fire     = bus.iss_valid & !hazard;
        set_vec  = (fire & bus.iss_rd_en) ? reg_bit(bus.iss_rd) : '0;
        clr_vec  = we ? reg_bit(wa) : '0;
        win_rd   = grant[1] ? bus.wb1_rd : bus.wb0_rd;
        win_data = grant[1] ? bus.wb1_data : bus.wb0_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy   <= '0;
            we     <= 1'b0;
            wa     <= '0;
            wd     <= '0;
            stalls <= '0;
        end else begin
            busy <= (busy | set_vec) & ~clr_vec;
            we   <= |grant && win_rd != '0;
            // A granted x0 write is consumed but leaves the port untouched.
            if (|grant && win_rd != '0) begin
                wa <= win_rd;
                wd <= win_data;
            end
            if (bus.iss_valid && hazard && stalls != '1)
                stalls <= stalls + STALL_CNT_W'(1);
        end
    end

    assign bus.iss_ready = !hazard;
    assign bus.wb0_ready = grant[0];
    assign bus.wb1_ready = grant[1];
    assign bus.rf_we     = we;
    assign bus.rf_wa     = wa;
    assign bus.rf_wd     = wd;
    assign bus.busy_vec  = busy;
    assign bus.stall_cnt = stalls;
endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// tb_regfile_wb_scoreboard: directed vectors; expected RegisterFile writes are queued
// at stimulus time and checked by a negedge monitor, status checked inline.
module tb_regfile_wb_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   errs  = 0;
    logic [36:0] exp_q[$];
    logic [31:0] rf_model[32];

    always #5 clk = ~clk;

    regfile_wb_scoreboard_if #(.XLEN(32), .STALL_CNT_W(16)) bus ();

    regfile_wb_scoreboard #(.XLEN(32), .STALL_CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit v, input logic [4:0] rs1, input bit e1,
                         input logic [4:0] rd, input bit ed);
        bus.iss_valid  = v;
        bus.iss_rs1    = rs1;
        bus.iss_rs1_en = e1;
        bus.iss_rs2    = 5'd0;
        bus.iss_rs2_en = 1'b0;
        bus.iss_rd     = rd;
        bus.iss_rd_en  = ed;
    endtask

    always @(negedge clk) begin
        if (rst && bus.rf_we) begin
            if (exp_q.size() == 0) begin
                tests++;
                errs++;
                $display("FAIL rf_write_unexpected: got wa=%0d wd=%0h expected none", bus.rf_wa, bus.rf_wd);
            end else begin
                chk("rf_write", {bus.rf_wa, bus.rf_wd}, exp_q.pop_front());
            end
            rf_model[bus.rf_wa] = bus.rf_wd;
        end
    end

    initial begin
        issue(0, 0, 0, 0, 0);
        bus.wb0_valid = 0; bus.wb0_rd = 0; bus.wb0_data = 0;
        bus.wb1_valid = 0; bus.wb1_rd = 0; bus.wb1_data = 0;
        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        // Reset
        repeat (3) tick();
        rst = 1'b1;
        issue(0, 6, 1, 9, 1);
        bus.iss_rs2 = 5'd7; bus.iss_rs2_en = 1'b1;
        #2;
        chk("rst_busy", bus.busy_vec, 0);
        chk("rst_we", bus.rf_we, 0);
        chk("rst_stall", bus.stall_cnt, 0);
        chk("rst_ready", bus.iss_ready, 1);
        // RAW on x6
        tick();
        issue(1, 0, 0, 6, 1);
        #2 chk("raw_issue_ready", bus.iss_ready, 1);
        tick();
        issue(1, 6, 1, 0, 0);
        bus.wb0_valid = 1; bus.wb0_rd = 6; bus.wb0_data = 25;
        exp_q.push_back({5'd6, 32'd25});
        #2;
        chk("raw_busy", bus.busy_vec, 32'h40);
        chk("raw_stall", bus.iss_ready, 0);
        chk("raw_wb0_ready", bus.wb0_ready, 1);
        tick();
        bus.wb0_valid = 0;
        #2;
        chk("raw_nobypass", bus.iss_ready, 0);
        chk("raw_we", bus.rf_we, 1);
        tick();
        #2;
        chk("raw_release", bus.iss_ready, 1);
        chk("raw_x6", rf_model[6], 25);
        chk("raw_stall_cnt", bus.stall_cnt, 2);
        issue(0, 0, 0, 0, 0);
        // WAW on x4
        tick();
        issue(1, 0, 0, 4, 1);
        #2 chk("waw_first", bus.iss_ready, 1);
        tick();
        #2;
        chk("waw_block", bus.iss_ready, 0);
        chk("waw_cnt0", bus.stall_cnt, 2);
        tick();
        #2 chk("waw_cnt1", bus.stall_cnt, 3);
        tick();
        bus.wb1_valid = 1; bus.wb1_rd = 4; bus.wb1_data = 32'h44;
        exp_q.push_back({5'd4, 32'h44});
        #2;
        chk("waw_cnt2", bus.stall_cnt, 4);
        chk("waw_wb1_ready", bus.wb1_ready, 1);
        tick();
        bus.wb1_valid = 0;
        #2 chk("waw_still_block", bus.iss_ready, 0);
        tick();
        #2;
        chk("waw_release", bus.iss_ready, 1);
        chk("waw_cnt3", bus.stall_cnt, 6);
        chk("waw_cleared", bus.busy_vec, 0);
        tick();
        issue(0, 0, 0, 0, 0);
        #2 chk("waw_reissued", bus.busy_vec, 32'h10);
        // Contention: wb0 wins first, then alternation
        bus.wb0_valid = 1; bus.wb0_rd = 4; bus.wb0_data = 7;
        bus.wb1_valid = 1; bus.wb1_rd = 8; bus.wb1_data = 9;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_q.push_back({5'd4, 32'd7});
            else            exp_q.push_back({5'd8, 32'd9});
            #1;
            chk("rr_wb0", bus.wb0_ready, (i % 2 == 0));
            chk("rr_wb1", bus.wb1_ready, (i % 2 == 1));
            tick();
        end
        bus.wb0_valid = 0; bus.wb1_valid = 0;
        tick();
        #2 chk("rr_busy_clear", bus.busy_vec, 0);
        // x0 issue and write
        issue(1, 0, 0, 0, 1);
        #1 chk("x0_ready", bus.iss_ready, 1);
        tick();
        issue(0, 0, 0, 0, 0);
        bus.wb1_valid = 1; bus.wb1_rd = 0; bus.wb1_data = 123;
        #2;
        chk("x0_busy", bus.busy_vec, 0);
        chk("x0_wb1_ready", bus.wb1_ready, 1);
        tick();
        bus.wb1_valid = 0;
        #2;
        chk("x0_no_we", bus.rf_we, 0);
        chk("x0_port_hold", {bus.rf_wa, bus.rf_wd}, {5'd8, 32'd9});
        // Reset mid-flight
        issue(1, 0, 0, 6, 1);
        tick();
        issue(0, 0, 0, 0, 0);
        bus.wb0_valid = 1; bus.wb0_rd = 6; bus.wb0_data = 55;
        #1 chk("mid_busy", bus.busy_vec, 32'h40);
        tick();
        bus.wb0_valid = 0;
        chk("mid_we", bus.rf_we, 1);
        #1 rst = 1'b0;
        #1;
        chk("mid_async_we", bus.rf_we, 0);
        chk("mid_async_busy", bus.busy_vec, 0);
        repeat (2) tick();
        rst = 1'b1;
        issue(1, 6, 1, 0, 0);
        #2;
        chk("mid_rs1_ready", bus.iss_ready, 1);
        chk("mid_stall_cnt", bus.stall_cnt, 0);
        tick();
        issue(0, 0, 0, 0, 0);
        repeat (2) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
